// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Sequencer states: idle, one request outstanding, discarding a stale response.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Default widths of a buffered fetch entry.
    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the redirect, instruction-memory and decoder-side signals of the fetch unit.
// "master" is the fetch unit itself; "slave" is the surrounding pipeline/memory.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head word, so the consumer never sees a
// combinational path from the write data. Flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_eff, push_eff;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);

    // Next storage/pointer state; the head register is preloaded from the post-update array.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
        end
        head_d = (count_d != '0) ? mem_d[rd_ptr_d] : '0;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time over a req/ack
// handshake, buffers returned words and hands them to decode over valid/ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_unit_if.master  bus_io
);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;

    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [1:0]        unused_pc_lsb;
    logic              inst_valid;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [CntW-1:0]   cnt_after_pop;
    logic              space_idle;
    logic              space_after_push;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    // Branch targets are always word aligned; the low bits are dropped.
    assign redir_pc      = {bus_io.redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_pc_lsb = bus_io.redirect_pc[1:0];
    assign pc_inc        = pc_q + ADDR_W'(INSTR_BYTES);

    assign inst_valid = !fifo_empty;
    assign pop        = inst_valid && bus_io.inst_ready;

    // In WAIT pc_q equals the outstanding address, so it tags the returned word.
    assign push = (state_q == WAIT) && bus_io.mem_ack && !bus_io.redirect;

    // Free-slot tests account for a decoder pop happening in the same cycle.
    assign cnt_after_pop    = fifo_count - CntW'(pop);
    assign space_idle       = !fifo_full || pop;
    assign space_after_push = (cnt_after_pop < CntW'(DEPTH - 1));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({pc_q, bus_io.mem_rdata}),
        .pop_i   (pop),
        .flush_i (bus_io.redirect),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign bus_io.mem_req    = req_q;
    assign bus_io.mem_addr   = addr_q;
    assign bus_io.inst_valid = inst_valid;
    assign bus_io.inst_pc    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign bus_io.inst_data  = fifo_head[DATA_W-1:0];

    // Fetch sequencer: PC update, request issue and stale-response draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.redirect) begin
                        // FIFO is flushed this edge, so there is always room.
                        pc_q    <= redir_pc;
                        addr_q  <= redir_pc;
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end else if (space_idle) begin
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_io.mem_ack) begin
                        if (bus_io.redirect) begin
                            // Response arrives with the redirect: drop it, refetch at target.
                            pc_q   <= redir_pc;
                            addr_q <= redir_pc;
                        end else begin
                            pc_q <= pc_inc;
                            if (space_after_push) begin
                                addr_q <= pc_inc;
                            end else begin
                                req_q   <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end else if (bus_io.redirect) begin
                        // Request must complete at its old address before retargeting.
                        pc_q    <= redir_pc;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus_io.redirect) begin
                        pc_q <= redir_pc;
                    end
                    if (bus_io.mem_ack) begin
                        addr_q  <= bus_io.redirect ? redir_pc : pc_q;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, wrap and reset.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_ack = 1'b0;
    int   total = 0;
    int   passed = 0;

    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_C3C3;
    endfunction

    function automatic fetch_entry_t entry_of(input logic [31:0] addr);
        fetch_entry_t e;
        e.pc   = addr;
        e.data = word_of(addr);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_head(input string tag, input logic [31:0] addr);
        fetch_entry_t e;
        e = entry_of(addr);
        check({tag, ".valid"}, {31'd0, bus.inst_valid}, 32'd1);
        check({tag, ".pc"}, bus.inst_pc, e.pc);
        check({tag, ".data"}, bus.inst_data, e.data);
    endtask

    // One clock: sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.redirect  = 1'b0;
        bus.mem_ack   = auto_ack ? bus.mem_req : 1'b0;
        bus.mem_rdata = word_of(bus.mem_addr);
    endtask

    task automatic apply_reset();
        auto_ack    = 1'b0;
        bus.mem_ack = 1'b0;
        bus.redirect = 1'b0;
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.inst_ready  = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst.mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst.mem_addr", bus.mem_addr, 32'h0);
        check("rst.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst.inst_data", bus.inst_data, 32'h0);
        check("rst.inst_pc", bus.inst_pc, 32'h0);

        // Streaming: ack in request cycle, decoder always ready -> one word per cycle.
        bus.inst_ready = 1'b1;
        auto_ack = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream.mem_req", {31'd0, bus.mem_req}, 32'd1);
            check("stream.mem_addr", bus.mem_addr, 32'(4 * i));
            if (i > 0) check_head("stream.head", 32'(4 * (i - 1)));
        end

        // Back-pressure: two words buffered, request dropped until the first pop.
        bus.inst_ready = 1'b0;
        apply_reset();
        auto_ack = 1'b1;
        tick();
        check("bp.first_addr", bus.mem_addr, 32'h0);
        tick();
        check_head("bp.head0", 32'h0);
        check("bp.second_addr", bus.mem_addr, 32'h4);
        tick();
        check("bp.full_req", {31'd0, bus.mem_req}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp.hold_req", {31'd0, bus.mem_req}, 32'd0);
            check("bp.hold_pc", bus.inst_pc, 32'h0);
        end
        bus.inst_ready = 1'b1;
        tick();
        check("bp.resume_req", {31'd0, bus.mem_req}, 32'd1);
        check("bp.resume_addr", bus.mem_addr, 32'h8);
        check_head("bp.head4", 32'h4);
        tick();
        check_head("bp.head8", 32'h8);

        // Redirect to an unaligned target while the FIFO is full.
        bus.inst_ready = 1'b0;
        apply_reset();
        auto_ack = 1'b1;
        repeat (3) tick();
        check("rdf.full_req", {31'd0, bus.mem_req}, 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        tick();
        check("rdf.flushed", {31'd0, bus.inst_valid}, 32'd0);
        check("rdf.req", {31'd0, bus.mem_req}, 32'd1);
        check("rdf.addr", bus.mem_addr, 32'h100);
        bus.inst_ready = 1'b1;
        tick();
        check_head("rdf.head100", 32'h100);
        tick();
        check_head("rdf.head104", 32'h104);

        // Redirect during WAIT with the ack held back three cycles.
        apply_reset();
        tick();
        check("drn.req", {31'd0, bus.mem_req}, 32'd1);
        check("drn.addr0", bus.mem_addr, 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drn.hold_req", {31'd0, bus.mem_req}, 32'd1);
            check("drn.hold_addr", bus.mem_addr, 32'h0);
            check("drn.no_valid", {31'd0, bus.inst_valid}, 32'd0);
        end
        bus.mem_ack = 1'b1;
        tick();
        check("drn.new_req", {31'd0, bus.mem_req}, 32'd1);
        check("drn.new_addr", bus.mem_addr, 32'h200);
        check("drn.dropped", {31'd0, bus.inst_valid}, 32'd0);
        auto_ack = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        check_head("drn.head200", 32'h200);

        // Redirect coinciding with an ack (outstanding address 0x204).
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        tick();
        check("rda.flushed", {31'd0, bus.inst_valid}, 32'd0);
        check("rda.req", {31'd0, bus.mem_req}, 32'd1);
        check("rda.addr", bus.mem_addr, 32'h300);
        tick();
        check_head("rda.head300", 32'h300);

        // PC wrap at the top of the address space.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        check("wrap.flushed", {31'd0, bus.inst_valid}, 32'd0);
        check("wrap.addr_fff8", bus.mem_addr, 32'hFFFF_FFF8);
        tick();
        check_head("wrap.head_fff8", 32'hFFFF_FFF8);
        check("wrap.addr_fffc", bus.mem_addr, 32'hFFFF_FFFC);
        tick();
        check_head("wrap.head_fffc", 32'hFFFF_FFFC);
        check("wrap.addr_0", bus.mem_addr, 32'h0);
        tick();
        check_head("wrap.head_0", 32'h0);
        check("wrap.addr_4", bus.mem_addr, 32'h4);

        // Asynchronous reset mid-WAIT, then a late ack after release.
        auto_ack    = 1'b0;
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("arst.mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("arst.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("arst.inst_pc", bus.inst_pc, 32'h0);
        check("arst.mem_addr", bus.mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("arst.first_req", {31'd0, bus.mem_req}, 32'd1);
        check("arst.first_addr", bus.mem_addr, 32'h0);
        check("arst.late_ack_ignored", {31'd0, bus.inst_valid}, 32'd0);
        auto_ack    = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = word_of(32'h0);
        tick();
        check_head("arst.head0", 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
